// File: rtl/lpif_lsm.sv
// PHY-side LPIF logical state machine: arbitrates link-layer state requests against LTSSM events.
// Optional stall_ack timeout is compiled in with LPIF_STALL_TIMEOUT_EN.
//
// state     | meaning
// ----------+-----------------------------------------------------------
// S_RST     | link not trained / reset, all status low
// S_ACT     | link active, trdy enabled
// S_STALL   | stall_req raised, waiting for link-layer drain (reports ACTIVE)
// S_RETRAIN | PHY retraining/recentering
// S_L1      | L1 entry requested; reports L1 once LTSSM confirms
// S_LERR    | link error, waits for LINKRESET request
module lpif_lsm #(
    parameter int STALL_TIMEOUT = 64,
    parameter int TO_W          = 7
) (
    input  logic       PCLK,
    input  logic       reset,
    input  logic [3:0] state_req,
    input  logic       stall_ack,
    input  logic       phy_linkup,
    input  logic       phy_recovery,
    input  logic       phy_in_l1,
    input  logic       phy_link_error,
    output logic [3:0] state_sts,
    output logic       link_up,
    output logic       stall_req,
    output logic       phyinrecenter,
    output logic       phyinl1,
    output logic       trdy_en,
    output logic       ltssm_retrain_req,
    output logic       ltssm_l1_req
);

    localparam logic [3:0] ENC_NOP       = 4'b0000;
    localparam logic [3:0] ENC_ACTIVE    = 4'b0001;
    localparam logic [3:0] ENC_L1        = 4'b0101;
    localparam logic [3:0] ENC_LINKRESET = 4'b1001;
    localparam logic [3:0] ENC_LINKERROR = 4'b1010;
    localparam logic [3:0] ENC_RETRAIN   = 4'b1011;

    if (2 ** TO_W <= STALL_TIMEOUT) begin : g_to_w_check
        $error("lpif_lsm: TO_W too narrow for STALL_TIMEOUT");
    end

    typedef enum logic [2:0] {
        S_RST, S_ACT, S_STALL, S_RETRAIN, S_L1, S_LERR
    } state_t;

    state_t     state_q, state_d;
    state_t     tgt_q, tgt_d;
    logic       l1_res_q, l1_res_d;
    logic [3:0] state_sts_q, state_sts_d;
    logic       link_up_q, link_up_d;
    logic       stall_req_q, stall_req_d;
    logic       phyinrecenter_q, phyinrecenter_d;
    logic       phyinl1_q, phyinl1_d;
    logic       trdy_en_q, trdy_en_d;
    logic       retrain_req_q, retrain_req_d;
    logic       l1_req_q, l1_req_d;
`ifdef LPIF_STALL_TIMEOUT_EN
    logic [TO_W-1:0] to_cnt_q, to_cnt_d;
`endif

    always_comb begin
        state_d       = state_q;
        tgt_d         = tgt_q;
        l1_res_d      = l1_res_q;
        retrain_req_d = 1'b0;

        if (phy_link_error) begin
            state_d = S_LERR;
        end else begin
            case (state_q)
                S_RST:
                    if (phy_linkup && state_req == ENC_ACTIVE) state_d = S_ACT;
                S_ACT:
                    if (phy_recovery) begin
                        state_d = S_STALL;
                        tgt_d   = S_RETRAIN;
                    end else if (state_req == ENC_RETRAIN) begin
                        state_d       = S_STALL;
                        tgt_d         = S_RETRAIN;
                        retrain_req_d = 1'b1;
                    end else if (state_req == ENC_L1) begin
                        state_d = S_STALL;
                        tgt_d   = S_L1;
                    end else if (!phy_linkup) begin
                        state_d = S_RST;
                    end
                S_STALL:
                    if (stall_ack) state_d = tgt_q;
`ifdef LPIF_STALL_TIMEOUT_EN
                    else if (to_cnt_q == TO_W'(STALL_TIMEOUT)) state_d = S_LERR;
`endif
                S_RETRAIN:
                    if (!phy_recovery) state_d = phy_linkup ? S_ACT : S_RST;
                // L1 exit only counts after the LTSSM has actually reached L1
                S_L1:
                    if (phy_in_l1)     l1_res_d = 1'b1;
                    else if (l1_res_q) state_d  = S_RETRAIN;
                S_LERR:
                    if (state_req == ENC_LINKRESET) state_d = S_RST;
                default:
                    state_d = S_RST;
            endcase
        end

        if (state_d != S_L1) l1_res_d = 1'b0;

        if (state_d != S_L1)      l1_req_d = 1'b0;
        else if (state_q != S_L1) l1_req_d = 1'b1;
        else                      l1_req_d = l1_req_q && (state_req != ENC_ACTIVE);

        link_up_d       = (state_d == S_ACT) || (state_d == S_STALL) ||
                          (state_d == S_RETRAIN) || (state_d == S_L1);
        trdy_en_d       = (state_d == S_ACT);
        stall_req_d     = (state_d == S_STALL);
        phyinrecenter_d = (state_d == S_RETRAIN);
        phyinl1_d       = (state_d == S_L1) && l1_res_d;

        case (state_d)
            S_ACT, S_STALL: state_sts_d = ENC_ACTIVE;
            S_RETRAIN:      state_sts_d = ENC_RETRAIN;
            S_L1:           state_sts_d = l1_res_d ? ENC_L1 : ENC_ACTIVE;
            S_LERR:         state_sts_d = ENC_LINKERROR;
            default:        state_sts_d = ENC_NOP;
        endcase
    end

`ifdef LPIF_STALL_TIMEOUT_EN
    always_comb begin
        to_cnt_d = to_cnt_q;
        if (state_q != S_STALL)  to_cnt_d = '0;
        else if (to_cnt_q != '1) to_cnt_d = to_cnt_q + TO_W'(1);
    end
`endif

    always_ff @(posedge PCLK or negedge reset) begin
        if (!reset) begin
            state_q         <= S_RST;
            tgt_q           <= S_RETRAIN;
            l1_res_q        <= 1'b0;
            state_sts_q     <= ENC_NOP;
            link_up_q       <= 1'b0;
            stall_req_q     <= 1'b0;
            phyinrecenter_q <= 1'b0;
            phyinl1_q       <= 1'b0;
            trdy_en_q       <= 1'b0;
            retrain_req_q   <= 1'b0;
            l1_req_q        <= 1'b0;
`ifdef LPIF_STALL_TIMEOUT_EN
            to_cnt_q        <= '0;
`endif
        end else begin
            state_q         <= state_d;
            tgt_q           <= tgt_d;
            l1_res_q        <= l1_res_d;
            state_sts_q     <= state_sts_d;
            link_up_q       <= link_up_d;
            stall_req_q     <= stall_req_d;
            phyinrecenter_q <= phyinrecenter_d;
            phyinl1_q       <= phyinl1_d;
            trdy_en_q       <= trdy_en_d;
            retrain_req_q   <= retrain_req_d;
            l1_req_q        <= l1_req_d;
`ifdef LPIF_STALL_TIMEOUT_EN
            to_cnt_q        <= to_cnt_d;
`endif
        end
    end

    assign state_sts         = state_sts_q;
    assign link_up           = link_up_q;
    assign stall_req         = stall_req_q;
    assign phyinrecenter     = phyinrecenter_q;
    assign phyinl1           = phyinl1_q;
    assign trdy_en           = trdy_en_q;
    assign ltssm_retrain_req = retrain_req_q;
    assign ltssm_l1_req      = l1_req_q;

endmodule

// File: tb/tb_lpif_lsm.sv
// Directed self-checking bench for lpif_lsm; expected values are hand-derived constants.
module tb_lpif_lsm;

    logic       PCLK = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] state_req = 4'b0000;
    logic       stall_ack = 1'b0;
    logic       phy_linkup = 1'b0;
    logic       phy_recovery = 1'b0;
    logic       phy_in_l1 = 1'b0;
    logic       phy_link_error = 1'b0;
    logic [3:0] state_sts;
    logic       link_up, stall_req, phyinrecenter, phyinl1, trdy_en;
    logic       ltssm_retrain_req, ltssm_l1_req;

    int total = 0;
    int bad   = 0;

    localparam logic [3:0] R_NOP = 4'b0000, R_ACT = 4'b0001, R_L1 = 4'b0101;
    localparam logic [3:0] R_LRST = 4'b1001, R_LERR = 4'b1010, R_RTR = 4'b1011;

    lpif_lsm #(.STALL_TIMEOUT(64), .TO_W(7)) dut (
        .PCLK(PCLK), .reset(reset), .state_req(state_req), .stall_ack(stall_ack),
        .phy_linkup(phy_linkup), .phy_recovery(phy_recovery), .phy_in_l1(phy_in_l1),
        .phy_link_error(phy_link_error), .state_sts(state_sts), .link_up(link_up),
        .stall_req(stall_req), .phyinrecenter(phyinrecenter), .phyinl1(phyinl1),
        .trdy_en(trdy_en), .ltssm_retrain_req(ltssm_retrain_req), .ltssm_l1_req(ltssm_l1_req)
    );

    always #5 PCLK = ~PCLK;

    // {state_sts, link_up, stall_req, phyinrecenter, phyinl1, trdy_en, retrain_req, l1_req}
    wire [10:0] outs = {state_sts, link_up, stall_req, phyinrecenter, phyinl1,
                        trdy_en, ltssm_retrain_req, ltssm_l1_req};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        for (int i = 0; i < n; i++) begin
            @(posedge PCLK);
            @(negedge PCLK);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tick(2);
        chk("reset_outs", 32'(outs), 32'h0);

        // bring-up
        reset = 1'b1; phy_linkup = 1'b1; state_req = R_ACT;
        tick();
        chk("bringup", 32'(outs), {21'h0, R_ACT, 7'b1000100});

        // retrain by request; state_req changes during STALL are ignored
        state_req = R_RTR;
        tick();
        chk("rtr_stall", 32'(outs), {21'h0, R_ACT, 7'b1100010});
        state_req = R_L1; phy_recovery = 1'b1;
        tick();
        chk("rtr_pulse_end", 32'(outs), {21'h0, R_ACT, 7'b1100000});
        tick(3);
        stall_ack = 1'b1;
        tick();
        chk("rtr_enter", 32'(outs), {21'h0, R_RTR, 7'b1010000});
        stall_ack = 1'b0; state_req = R_ACT;
        tick();
        chk("rtr_hold", 32'(state_sts), 32'(R_RTR));
        phy_recovery = 1'b0;
        tick();
        chk("rtr_exit", 32'(outs), {21'h0, R_ACT, 7'b1000100});

        // L1 round trip
        state_req = R_L1;
        tick();
        stall_ack = 1'b1;
        tick();
        chk("l1_req_on", 32'(outs), {21'h0, R_ACT, 7'b1000001});
        stall_ack = 1'b0;
        tick();
        chk("l1_wait_phy", 32'(outs), {21'h0, R_ACT, 7'b1000001});
        phy_in_l1 = 1'b1;
        tick();
        chk("l1_resident", 32'(outs), {21'h0, R_L1, 7'b1001001});
        state_req = R_ACT;
        tick();
        chk("l1_req_off", 32'(outs), {21'h0, R_L1, 7'b1001000});
        phy_in_l1 = 1'b0;
        tick();
        chk("l1_exit_rtr", 32'(outs), {21'h0, R_RTR, 7'b1010000});
        tick();
        chk("l1_back_act", 32'(state_sts), 32'(R_ACT));

        // phy_recovery outranks a RETRAIN request: no retrain pulse; held ack finishes STALL in 1 cycle
        stall_ack = 1'b1; phy_recovery = 1'b1; state_req = R_RTR;
        tick();
        chk("rec_prio", 32'(outs), {21'h0, R_ACT, 7'b1100000});
        tick();
        chk("held_ack", 32'(state_sts), 32'(R_RTR));
        stall_ack = 1'b0; phy_recovery = 1'b0; state_req = R_ACT;
        tick();
        chk("held_ack_act", 32'(state_sts), 32'(R_ACT));

        // error wins over simultaneous stall_ack
        state_req = R_L1;
        tick();
        stall_ack = 1'b1; phy_link_error = 1'b1;
        tick();
        chk("err_prio", 32'(outs), {21'h0, R_LERR, 7'b0000000});
        stall_ack = 1'b0; state_req = R_LRST;
        tick();
        chk("err_held", 32'(state_sts), 32'(R_LERR));
        phy_link_error = 1'b0; state_req = R_ACT;
        tick();
        chk("err_need_lrst", 32'(state_sts), 32'(R_LERR));
        state_req = R_LRST;
        tick();
        chk("err_exit", 32'(outs), 32'h0);
        state_req = R_ACT;
        tick();
        chk("rst_to_act", 32'(state_sts), 32'(R_ACT));

        // link drop in ACT
        phy_linkup = 1'b0;
        tick();
        chk("linkdown", 32'(outs), 32'h0);
        phy_linkup = 1'b1;
        tick();
        chk("relink", 32'(trdy_en), 32'h1);

        // async reset mid-RETRAIN
        phy_recovery = 1'b1;
        tick();
        stall_ack = 1'b1;
        tick();
        chk("pre_async", 32'(state_sts), 32'(R_RTR));
        stall_ack = 1'b0;
        #2 reset = 1'b0;
        #1 chk("async_rst", 32'(outs), 32'h0);
        @(negedge PCLK);
        reset = 1'b1; phy_recovery = 1'b0;
        tick();
        chk("post_async", 32'(state_sts), 32'(R_ACT));

        // stall timeout
        state_req = R_RTR;
        tick();
        state_req = R_ACT;
`ifdef LPIF_STALL_TIMEOUT_EN
        tick(64);
        chk("to_not_yet", 32'(stall_req), 32'h1);
        tick();
        chk("to_lerr", 32'(outs), {21'h0, R_LERR, 7'b0000000});
`else
        tick(1000);
        chk("no_to_sts", 32'(state_sts), 32'(R_ACT));
        chk("no_to_stall", 32'(stall_req), 32'h1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/lpif_lsm.md
# lpif_lsm

PHY-side LPIF logical state machine for the PCIe5 PHY. It sits between the LTSSM/physical layer and the LPIF boundary driven toward the link layer. It arbitrates link-layer state requests against physical-layer link events and produces the LPIF status signals (`state_sts`, `link_up`, `phyinrecenter`, `phyinl1`). It also runs the `stall_req`/`stall_ack` drain handshake before any retrain or L1 entry, and provides the transmit-ready enable consumed by the LPIF data path.

## Interface
Parameters:
- `STALL_TIMEOUT`, 64: cycles allowed between `stall_req` rise and `stall_ack` before the block declares a link error. Only used when the timeout feature is compiled in.
- `TO_W`, 7: width of the stall timeout counter. Must satisfy 2^TO_W > STALL_TIMEOUT.

Ports:
- `PCLK`  in  1  sole clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `state_req`  in  4  LPIF state request from the link layer.
- `stall_ack`  in  1  link layer has drained traffic in response to `stall_req`.
- `phy_linkup`  in  1  LTSSM reports L0 reached / link trained.
- `phy_recovery`  in  1  LTSSM is in Recovery.
- `phy_in_l1`  in  1  LTSSM has completed L1 entry (electrical idle).
- `phy_link_error`  in  1  unrecoverable physical-layer error.
- `state_sts`  out  4  LPIF state status.
- `link_up`  out  1  LPIF link_up.
- `stall_req`  out  1  LPIF stall request.
- `phyinrecenter`  out  1  PHY is retraining/recentering.
- `phyinl1`  out  1  PHY is in L1.
- `trdy_en`  out  1  enable for LPIF `trdy` generation in the data path.
- `ltssm_retrain_req`  out  1  single-cycle pulse requesting LTSSM Recovery.
- `ltssm_l1_req`  out  1  level request for L1 entry. Deasserting it requests L1 exit.

## Operation
- Encodings, shared by `state_req` and `state_sts`:
  - NOP/RESET 4'b0000
  - ACTIVE 4'b0001
  - L1 4'b0101
  - LINKRESET 4'b1001
  - LINKERROR 4'b1010
  - RETRAIN 4'b1011
- FSM states: RST, ACT, STALL, RETRAIN, L1, LERR. `state_sts` mirrors the current state. STALL reports ACTIVE.
- `phy_link_error`=1 in any state forces LERR on the next cycle. This has priority over every other transition.
- RST → ACT when `phy_linkup`=1 and `state_req`=ACTIVE.
- ACT transitions, in priority order:
  - `phy_recovery`=1 → STALL, target RETRAIN.
  - `state_req`=RETRAIN → STALL, target RETRAIN, and `ltssm_retrain_req` pulses for 1 cycle.
  - `state_req`=L1 → STALL, target L1.
  - `phy_linkup`=0 → RST.
- STALL: `stall_req`=1 and `trdy_en`=0. On `stall_ack`=1 the FSM enters the target state and `stall_req` drops in the same registered update.
- RETRAIN: `phyinrecenter`=1.
  - → ACT when `phy_recovery`=0 and `phy_linkup`=1.
  - → RST when `phy_linkup`=0 and `phy_recovery`=0.
- L1 entry and residency:
  - `ltssm_l1_req`=1 from STALL exit onward.
  - `phyinl1`=1 and `state_sts`=L1 only once `phy_in_l1`=1. Until then `state_sts` stays ACTIVE.
- L1 exit:
  - `state_req`=ACTIVE deasserts `ltssm_l1_req`.
  - When `phy_in_l1`=0, the FSM moves to RETRAIN, because L1 exit passes through Recovery.
- LERR: `link_up`=0, `trdy_en`=0, `stall_req`=0. Exits to RST only when `phy_link_error`=0 and `state_req`=LINKRESET.
- `link_up`=1 in ACT, STALL, RETRAIN and L1. It is 0 in RST and LERR.
- `trdy_en`=1 only in ACT.

## Timing
- All outputs are registered. Every input event is reflected on the outputs exactly 1 PCLK later.
- Reset (`reset`=0), asynchronous: FSM=RST and every output is 0, which makes `state_sts`=4'b0000.
- `stall_ack` is sampled only in STALL. A `stall_ack` held high from an earlier STALL visit completes the next STALL in 1 cycle.
- Simultaneous `stall_ack` and `phy_link_error`: LERR wins.
- `state_req` changes while in STALL are ignored. The target is latched on STALL entry.
- Timeout counter:
  - Clears on STALL entry and increments each STALL cycle.
  - Saturates at 2^TO_W−1 and never wraps.

## Configuration
- `LPIF_STALL_TIMEOUT_EN` defined:
  - If `stall_ack` is not seen within STALL_TIMEOUT cycles of STALL entry, the FSM goes to LERR on cycle STALL_TIMEOUT+1.
  - `stall_req` drops in that same update.
- Undefined: STALL waits indefinitely, and the counter logic is not instantiated.

## Test plan
- Bring-up: release `reset`, set `phy_linkup`=1 and `state_req`=ACTIVE → `state_sts`=0001, `link_up`=1 and `trdy_en`=1 one cycle later.
- Retrain by request: in ACT, `state_req`=RETRAIN → `ltssm_retrain_req` pulses for 1 cycle and `stall_req`=1. Assert `stall_ack` 5 cycles later → `state_sts`=1011 and `phyinrecenter`=1. Drop `phy_recovery` → `state_sts` returns to 0001.
- L1 round trip: `state_req`=L1 then `stall_ack` → `ltssm_l1_req`=1. `phy_in_l1`=1 → `state_sts`=0101 and `phyinl1`=1. `state_req`=ACTIVE → `ltssm_l1_req`=0. `phy_in_l1`=0 → `state_sts`=1011.
- Error priority: in STALL, assert `stall_ack` and `phy_link_error` together → `state_sts`=1010, `link_up`=0, `stall_req`=0. `state_req`=LINKRESET with `phy_link_error`=0 → `state_sts`=0000.
- Timeout (macro on, STALL_TIMEOUT=64): hold `stall_ack`=0 → LERR at cycle 65 after STALL entry. Macro off → STALL persists beyond 1000 cycles.
- Async reset mid-RETRAIN: assert `reset`=0 between clock edges → all outputs 0 immediately, without waiting for a PCLK edge.
